// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
// Shared definitions for the mem_responder slice: FSM state encoding,
// transaction owner encoding and the default values for the wait-state count
// and memory depth.
// -----------------------------------------------------------------------------
package mem_responder_pkg;

    localparam int DEFAULT_WAIT_CYCLES = 1;    // wait states before ack (0..7)
    localparam int DEFAULT_DEPTH       = 256;  // number of 8-bit words
    localparam int DATA_W              = 8;
    localparam int ADDR_W              = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_MON = 1'b1
    } owner_e;

endpackage : mem_responder_pkg

// File: rtl/mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
// DEPTH x 8 storage with a synchronous write and a combinational read, both on
// the same address. The caller is responsible for only presenting in-range
// addresses on a write and for masking out-of-range reads.
//
// Ports
//   clk      : clock, write occurs on the rising edge
//   we_i     : write enable
//   addr_i   : word address (read and write)
//   wdata_i  : write data
//   rdata_o  : combinational read data at addr_i
// -----------------------------------------------------------------------------
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int IDX_W = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; contents must survive a reset of the
    // surrounding logic, and leaving it out keeps the array mappable to RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule : mem_array

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory slave with two request ports (CPU and monitor) sharing one DEPTH x 8
// array. Fixed priority arbitration (CPU wins), WAIT_CYCLES wait states, then a
// one-cycle acknowledge to the owner of the transaction. Writes commit and
// reads are captured on the clock edge that enters the ACK state.
//
// Ports
//   clk, n_reset                      : clock, async active-low reset
//   cpu_req/we/addr/wdata             : CPU request (held until cpu_ack)
//   cpu_rdata, cpu_ack                : CPU read data / completion pulse
//   mon_req/we/addr/wdata             : monitor request (held until mon_ack)
//   mon_rdata, mon_ack                : monitor read data / completion pulse
//   busy                              : high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int DEPTH       = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              mon_req,
    input  logic              mon_we,
    input  logic [ADDR_W-1:0] mon_addr,
    input  logic [DATA_W-1:0] mon_wdata,
    output logic [DATA_W-1:0] mon_rdata,
    output logic              mon_ack,
    output logic              busy
);

    localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Guarded so WAIT_CYCLES = 0 does not wrap; WAIT is never entered then.
    localparam logic [2:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    state_e              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    owner_e              owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   mon_rdata_q, mon_rdata_d;

    // The transaction being worked on this cycle: straight from the winning
    // port while IDLE (so WAIT_CYCLES = 0 can commit on the accepting edge),
    // otherwise the latched copy.
    owner_e              txn_owner;
    logic                txn_we;
    logic [ADDR_W-1:0]   txn_addr;
    logic [DATA_W-1:0]   txn_wdata;

    logic                enter_ack;
    logic                addr_ok;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_rdata;
    logic [DATA_W-1:0]   rd_val;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        txn_owner = owner_q;
        txn_we    = we_q;
        txn_addr  = addr_q;
        txn_wdata = wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    txn_owner = OWN_CPU;
                    txn_we    = cpu_we;
                    txn_addr  = cpu_addr;
                    txn_wdata = cpu_wdata;
                end else if (mon_req) begin
                    txn_owner = OWN_MON;
                    txn_we    = mon_we;
                    txn_addr  = mon_addr;
                    txn_wdata = mon_wdata;
                end
                if (cpu_req || mon_req) begin
                    owner_d = txn_owner;
                    we_d    = txn_we;
                    addr_d  = txn_addr;
                    wdata_d = txn_wdata;
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ACK always returns to IDLE, so next-state ACK is exactly the entry edge.
    assign enter_ack = (state_d == ST_ACK);
    assign addr_ok   = (int'(txn_addr) < DEPTH);
    // Held in reset the FSM sits in IDLE while state_d may still say ACK;
    // gating with n_reset keeps a request under reset from writing memory.
    assign mem_we    = enter_ack && txn_we && addr_ok && n_reset;
    assign rd_val    = addr_ok ? mem_rdata : '0;

    always_comb begin
        cpu_rdata_d = cpu_rdata_q;
        mon_rdata_d = mon_rdata_q;
        if (enter_ack && !txn_we) begin
            if (txn_owner == OWN_CPU) begin
                cpu_rdata_d = rd_val;
            end else begin
                mon_rdata_d = rd_val;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            owner_q     <= OWN_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            mon_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            mon_rdata_q <= mon_rdata_d;
        end
    end

    mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem_array (
        .clk     (clk),
        .we_i    (mem_we),
        .addr_i  (txn_addr[IDX_W-1:0]),
        .wdata_i (txn_wdata),
        .rdata_o (mem_rdata)
    );

    assign busy      = (state_q != ST_IDLE);
    assign cpu_ack   = (state_q == ST_ACK) && (owner_q == OWN_CPU);
    assign mon_ack   = (state_q == ST_ACK) && (owner_q == OWN_MON);
    assign cpu_rdata = cpu_rdata_q;
    assign mon_rdata = mon_rdata_q;

endmodule : mem_responder
